// File: rtl/axil_regfile_axis_rd.sv
// AXI-Lite accessible register file whose contents can be streamed out as an
// AXI-Stream burst of registers 0..axis_read_num, concurrently with bus access.
module axil_regfile_axis_rd #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int REG_NUM    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    input  logic [31:0]           axis_read_num,
    input  logic                  axis_start,
    output logic                  axis_busy,
    output logic                  axis_done
);

    localparam int ADDR_LSB = (DATA_WIDTH/32) + 1;
    localparam int IDX_BITS = $clog2(REG_NUM);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    logic [IDX_BITS-1:0]   wr_idx;
    logic [IDX_BITS-1:0]   rd_idx;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  wr_fire;
    logic                  rd_fire;

    state_t                state;
    state_t                state_next;
    logic [IDX_BITS-1:0]   ptr;
    logic [IDX_BITS-1:0]   ptr_next;
    logic [IDX_BITS-1:0]   last_idx;
    logic [IDX_BITS-1:0]   last_next;
    logic [IDX_BITS-1:0]   load_idx;
    logic                  load_en;
    logic                  done_next;
    logic                  beat;

    logic                  unused;

    assign unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr, axis_read_num};

    assign wr_idx  = s_axil_awaddr[ADDR_LSB +: IDX_BITS];
    assign rd_idx  = s_axil_araddr[ADDR_LSB +: IDX_BITS];
    assign wr_fire = s_axil_awready && s_axil_awvalid && s_axil_wvalid;
    assign rd_fire = s_axil_arready && s_axil_arvalid;

    assign s_axil_bresp = '0;
    assign s_axil_rresp = '0;

    always_comb begin
        wr_mask = '0;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            wr_mask[b*8 +: 8] = {8{s_axil_wstrb[b]}};
        end
    end

    // One process per word keeps the array write free of looped delayed assignments.
    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs[g] <= '0;
            end else if (wr_fire && wr_idx == IDX_BITS'(g)) begin
                regs[g] <= (regs[g] & ~wr_mask) | (s_axil_wdata & wr_mask);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
        end else begin
            s_axil_awready <= s_axil_awvalid && s_axil_wvalid && !s_axil_awready && !s_axil_bvalid;
            s_axil_wready  <= s_axil_awvalid && s_axil_wvalid && !s_axil_awready && !s_axil_bvalid;
            if (wr_fire) begin
                s_axil_bvalid <= 1'b1;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
        end else begin
            s_axil_arready <= s_axil_arvalid && !s_axil_arready && (!s_axil_rvalid || s_axil_rready);
            if (rd_fire) begin
                s_axil_rdata  <= regs[rd_idx];
                s_axil_rvalid <= 1'b1;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    // tvalid is implied by the STREAM state; tlast is derived so it can never
    // disagree with the pointer.
    assign m_axis_tvalid = (state == STREAM);
    assign m_axis_tlast  = m_axis_tvalid && (ptr == last_idx);
    assign axis_busy     = (state == STREAM);
    assign beat          = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        last_next  = last_idx;
        load_en    = 1'b0;
        load_idx   = ptr;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (axis_start) begin
                    state_next = STREAM;
                    ptr_next   = '0;
                    last_next  = axis_read_num[IDX_BITS-1:0];
                    load_en    = 1'b1;
                    load_idx   = '0;
                end
            end
            STREAM: begin
                if (beat) begin
                    if (m_axis_tlast) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        ptr_next = ptr + IDX_BITS'(1);
                        load_en  = 1'b1;
                        load_idx = ptr + IDX_BITS'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            last_idx     <= '0;
            axis_done    <= 1'b0;
            m_axis_tdata <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            last_idx  <= last_next;
            axis_done <= done_next;
            if (load_en) begin
                m_axis_tdata <= regs[load_idx];
            end
        end
    end

endmodule

// File: tb/tb_axil_regfile_axis_rd.sv
// Self-checking bench for axil_regfile_axis_rd: randomized bus/stream traffic
// compared against an array model of the register file.
module tb_axil_regfile_axis_rd;

    localparam int RN = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [63:0] s_axil_wdata;
    logic [7:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [63:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [31:0] axis_read_num;
    logic        axis_start;
    logic        axis_busy;
    logic        axis_done;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [RN];
    logic [63:0] got_data [$];
    bit          got_last [$];
    int          stall_err;
    int          burst_cycles;
    bit          done_seen;
    bit          idle_after;
    bit          first_valid;
    bit          timed_out;

    always #5 clk = ~clk;

    axil_regfile_axis_rd #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(32),
        .STRB_WIDTH(8),
        .REG_NUM(RN)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .axis_read_num(axis_read_num), .axis_start(axis_start),
        .axis_busy(axis_busy), .axis_done(axis_done)
    );

    // Random upper bits and sub-word bits, which the register file must ignore.
    function automatic logic [31:0] addr_of(input int unsigned idx);
        return ($urandom & 32'hFFFF_E000) | (idx << 3) | ($urandom & 32'h7);
    endfunction

    task automatic axil_write(input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, output bit ok, output int lat);
        int unsigned idx;
        logic [63:0] m;
        ok = 1'b0;
        lat = 0;
        s_axil_awaddr = addr; s_axil_awprot = 3'b000; s_axil_wdata = data; s_axil_wstrb = strb;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat = i + 1;
            if (s_axil_awready && s_axil_wready) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        if (s_axil_awready || !s_axil_bvalid || s_axil_bresp !== 2'b00) ok = 1'b0;
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
        if (s_axil_bvalid) ok = 1'b0;
        idx = int'(addr[12:3]);
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{strb[b]}};
        model[idx] = (model[idx] & ~m) | (data & m);
    endtask

    task automatic axil_read(input logic [31:0] addr, output logic [63:0] data,
                             output logic [1:0] resp, output bit ok, output int lat);
        ok = 1'b0;
        lat = 0;
        s_axil_araddr = addr; s_axil_arprot = 3'b000; s_axil_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat = i + 1;
            if (s_axil_arready) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        if (!s_axil_rvalid) ok = 1'b0;
        data = s_axil_rdata;
        resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
        if (s_axil_rvalid) ok = 1'b0;
    endtask

    // Drives one burst and records every accepted beat; mode 0 = always ready,
    // 1 = ready toggling 1010..., 2 = random ready. restart pulses start mid-burst.
    task automatic run_burst(input int num, input int mode, input bit restart);
        bit tr, v, l, pl, prev_stall, last_seen;
        logic [63:0] d, pd;
        got_data.delete(); got_last.delete();
        stall_err = 0; burst_cycles = 0; done_seen = 0; idle_after = 0; timed_out = 1;
        prev_stall = 0; last_seen = 0; pd = '0; pl = 0;
        axis_read_num = num; axis_start = 1'b1; m_axis_tready = 1'b0;
        @(negedge clk);
        axis_start = 1'b0;
        first_valid = m_axis_tvalid;
        for (int cyc = 0; cyc < 200; cyc++) begin
            case (mode)
                0: tr = 1'b1;
                1: tr = (cyc % 2 == 0);
                default: tr = 1'($urandom_range(0, 1));
            endcase
            m_axis_tready = tr;
            if (restart) begin
                axis_start = (cyc == 1);
                if (cyc == 1) axis_read_num = num + 5;
            end
            v = m_axis_tvalid; d = m_axis_tdata; l = m_axis_tlast;
            if (prev_stall && (d !== pd || l !== pl)) stall_err++;
            prev_stall = v && !tr; pd = d; pl = l;
            if (v && tr) begin
                got_data.push_back(d);
                got_last.push_back(l);
                if (l) last_seen = 1;
            end
            @(negedge clk);
            if (last_seen) begin
                burst_cycles = cyc + 1;
                timed_out = 0;
                break;
            end
        end
        axis_start = 1'b0; m_axis_tready = 1'b0;
        done_seen = !timed_out && axis_done;
        idle_after = !m_axis_tvalid && !axis_busy;
        @(negedge clk);
        if (axis_done) done_seen = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid, m_axis_tvalid, m_axis_tlast, axis_busy, axis_done} !== 9'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000000", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid, m_axis_tvalid, m_axis_tlast, axis_busy, axis_done});
        end
        checks++;
        if ({s_axil_bresp, s_axil_rresp, s_axil_rdata, m_axis_tdata} !== '0) begin
            errors++; $display("FAIL reset_data: got rdata=%h tdata=%h bresp=%0d rresp=%0d expected all 0", s_axil_rdata, m_axis_tdata, s_axil_bresp, s_axil_rresp);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_axis_tvalid, axis_busy, axis_done, s_axil_bvalid, s_axil_rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_release: got %b expected 00000", {m_axis_tvalid, axis_busy, axis_done, s_axil_bvalid, s_axil_rvalid});
        end
    endtask

    task automatic test_basic_burst();
        bit ok; int lat;
        for (int unsigned i = 0; i < 4; i++) begin
            axil_write(32'(i * 8), 64'((i + 1) * 'h11), 8'hFF, ok, lat);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_write%0d: got ok=%0b expected ok=1", i, ok); end
        end
        run_burst(3, 0, 0);
        checks++;
        if (got_data.size() != 4 || timed_out) begin
            errors++; $display("FAIL basic_count: got %0d beats expected 4", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 64'((i + 1) * 'h11) || got_last[i] !== (i == 3)) begin
                errors++; $display("FAIL basic_beat%0d: got %h last=%0b expected %h last=%0b", i, got_data[i], got_last[i], 64'((i + 1) * 'h11), (i == 3));
            end
        end
        checks++;
        if (!first_valid || burst_cycles != 4 || !done_seen || !idle_after) begin
            errors++; $display("FAIL basic_timing: got first_valid=%0b cycles=%0d done=%0b idle=%0b expected 1 4 1 1", first_valid, burst_cycles, done_seen, idle_after);
        end
    endtask

    task automatic test_stall();
        run_burst(3, 1, 0);
        checks++;
        if (got_data.size() != 4 || timed_out) begin
            errors++; $display("FAIL stall_count: got %0d beats expected 4", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== model[i] || got_last[i] !== (i == 3)) begin
                errors++; $display("FAIL stall_beat%0d: got %h last=%0b expected %h last=%0b", i, got_data[i], got_last[i], model[i], (i == 3));
            end
        end
        checks++;
        if (stall_err != 0 || !done_seen) begin
            errors++; $display("FAIL stall_hold: got changes=%0d done=%0b expected 0 1", stall_err, done_seen);
        end
    endtask

    task automatic test_strobe();
        bit ok; int lat; logic [63:0] rd; logic [1:0] rr;
        axil_write(addr_of(5), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ok, lat);
        axil_write(addr_of(5), 64'h0000_0000_0000_00AA, 8'h01, ok, lat);
        axil_read(addr_of(5), rd, rr, ok, lat);
        checks++;
        if (!ok || rd !== 64'hFFFF_FFFF_FFFF_FFAA || rr !== 2'b00) begin
            errors++; $display("FAIL strobe_idx5: got %h resp=%0d ok=%0b expected ffffffffffffffaa resp=0", rd, rr, ok);
        end
        for (int n = 0; n < 8; n++) begin
            int unsigned idx;
            idx = $urandom_range(0, RN - 1);
            axil_write(addr_of(idx), {$urandom, $urandom}, 8'($urandom), ok, lat);
            axil_read(addr_of(idx), rd, rr, ok, lat);
            checks++;
            if (!ok || rd !== model[idx] || rr !== 2'b00) begin
                errors++; $display("FAIL strobe_rand idx=%0d: got %h resp=%0d expected %h resp=0", idx, rd, rr, model[idx]);
            end
        end
    endtask

    task automatic test_single_and_restart();
        run_burst(0, 0, 0);
        checks++;
        if (got_data.size() != 1 || got_data[0] !== model[0] || got_last[0] !== 1'b1 || !done_seen) begin
            errors++; $display("FAIL single_beat: got %0d beats first=%h expected 1 beat %h with tlast", got_data.size(), got_data.size() ? got_data[0] : 64'h0, model[0]);
        end
        run_burst(2, 0, 1);
        checks++;
        if (got_data.size() != 3 || timed_out) begin
            errors++; $display("FAIL restart_count: got %0d beats expected 3", got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== model[i] || got_last[i] !== (i == 2)) begin
                errors++; $display("FAIL restart_beat%0d: got %h last=%0b expected %h last=%0b", i, got_data[i], got_last[i], model[i], (i == 2));
            end
        end
        checks++;
        if (!idle_after) begin errors++; $display("FAIL restart_idle: got busy/valid set expected idle"); end
    endtask

    task automatic test_truncate();
        run_burst(RN + 2, 0, 0);
        checks++;
        if (got_data.size() != 3 || got_last[got_data.size() - 1] !== 1'b1) begin
            errors++; $display("FAIL truncate_count: got %0d beats expected 3", got_data.size());
        end
    endtask

    task automatic test_random_burst();
        bit ok; int lat; int num;
        for (int r = 0; r < 6; r++) begin
            repeat (3) axil_write(addr_of($urandom_range(0, 15)), {$urandom, $urandom}, 8'($urandom_range(1, 255)), ok, lat);
            num = $urandom_range(0, 15);
            run_burst(num, 2, 0);
            checks++;
            if (got_data.size() != num + 1 || stall_err != 0 || !done_seen) begin
                errors++; $display("FAIL rand_burst%0d: got %0d beats changes=%0d done=%0b expected %0d 0 1", r, got_data.size(), stall_err, done_seen, num + 1);
            end
            for (int i = 0; i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== model[i] || got_last[i] !== (i == num)) begin
                    errors++; $display("FAIL rand_beat%0d_%0d: got %h last=%0b expected %h last=%0b", r, i, got_data[i], got_last[i], model[i], (i == num));
                end
            end
        end
    endtask

    task automatic test_same_edge_write();
        logic [63:0] old1, new1;
        old1 = model[1];
        new1 = ~old1 ^ 64'h5A5A;
        axis_read_num = 1; axis_start = 1'b1; m_axis_tready = 1'b1;
        s_axil_awaddr = 32'h8; s_axil_wdata = new1; s_axil_wstrb = 8'hFF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        @(negedge clk);
        axis_start = 1'b0;
        checks++;
        if (m_axis_tdata !== model[0] || !s_axil_awready) begin
            errors++; $display("FAIL same_edge_first: got %h awready=%0b expected %h awready=1", m_axis_tdata, s_axil_awready, model[0]);
        end
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        checks++;
        if (m_axis_tdata !== old1 || m_axis_tlast !== 1'b1 || !s_axil_bvalid) begin
            errors++; $display("FAIL same_edge_old: got %h last=%0b bvalid=%0b expected %h last=1 bvalid=1", m_axis_tdata, m_axis_tlast, s_axil_bvalid, old1);
        end
        model[1] = new1;
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0; m_axis_tready = 1'b0;
        checks++;
        if (!axis_done || m_axis_tvalid) begin
            errors++; $display("FAIL same_edge_done: got done=%0b tvalid=%0b expected 1 0", axis_done, m_axis_tvalid);
        end
        @(negedge clk);
        run_burst(1, 0, 0);
        checks++;
        if (got_data.size() != 2 || got_data[1] !== new1) begin
            errors++; $display("FAIL same_edge_new: got %0d beats last=%h expected 2 beats last=%h", got_data.size(), got_data.size() > 1 ? got_data[1] : 64'h0, new1);
        end
    endtask

    task automatic test_concurrent();
        bit wok, rok; int wlat, rlat; logic [63:0] rd, wd; logic [1:0] rr;
        wd = {$urandom, $urandom};
        fork
            run_burst(15, 0, 0);
            begin
                @(negedge clk);
                axil_write(addr_of(200), wd, 8'hFF, wok, wlat);
                axil_read(addr_of(5), rd, rr, rok, rlat);
            end
        join
        checks++;
        if (burst_cycles != 16 || got_data.size() != 16) begin
            errors++; $display("FAIL conc_stream: got cycles=%0d beats=%0d expected 16 16", burst_cycles, got_data.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== model[i]) begin
                errors++; $display("FAIL conc_beat%0d: got %h expected %h", i, got_data[i], model[i]);
            end
        end
        checks++;
        if (!wok || wlat != 1 || !rok || rlat != 1 || rd !== model[5]) begin
            errors++; $display("FAIL conc_bus: got wok=%0b wlat=%0d rok=%0b rlat=%0d rd=%h expected 1 1 1 1 %h", wok, wlat, rok, rlat, rd, model[5]);
        end
        axil_read(addr_of(200), rd, rr, rok, rlat);
        checks++;
        if (rd !== wd) begin errors++; $display("FAIL conc_wrback: got %h expected %h", rd, wd); end
    endtask

    task automatic test_aw_without_w();
        int seen; bit held; logic [63:0] rd; logic [1:0] rr; bit ok; int lat; logic [63:0] d;
        d = {$urandom, $urandom};
        s_axil_awaddr = 32'h38; s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_axil_awready || s_axil_wready) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL aw_only: got %0d ready cycles expected 0", seen); end
        s_axil_wdata = d; s_axil_wstrb = 8'hFF; s_axil_wvalid = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axil_awready && s_axil_wready) begin seen = i + 1; break; end
        end
        @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        checks++;
        if (seen != 1 || s_axil_awready || s_axil_wready) begin
            errors++; $display("FAIL aw_pulse: got latency=%0d awready=%0b wready=%0b expected 1 0 0", seen, s_axil_awready, s_axil_wready);
        end
        held = 1;
        repeat (3) begin
            if (!s_axil_bvalid || s_axil_bresp !== 2'b00) held = 0;
            @(negedge clk);
        end
        checks++;
        if (!held || !s_axil_bvalid) begin errors++; $display("FAIL b_hold: got bvalid=%0b expected 1 until bready", s_axil_bvalid); end
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
        checks++;
        if (s_axil_bvalid) begin errors++; $display("FAIL b_clear: got bvalid=1 expected 0"); end
        model[7] = d;
        axil_read(addr_of(7), rd, rr, ok, lat);
        checks++;
        if (rd !== d) begin errors++; $display("FAIL aw_wrback: got %h expected %h", rd, d); end
    endtask

    task automatic test_reset_midburst();
        logic [63:0] rd; logic [1:0] rr; bit ok; int lat;
        axis_read_num = 3; axis_start = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        axis_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== model[2]) begin
            errors++; $display("FAIL midrst_pre: got tvalid=%0b tdata=%h expected 1 %h", m_axis_tvalid, m_axis_tdata, model[2]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid || m_axis_tlast || axis_busy || axis_done || m_axis_tdata !== 64'h0) begin
            errors++; $display("FAIL midrst_async: got tvalid=%0b tlast=%0b busy=%0b done=%0b tdata=%h expected all 0", m_axis_tvalid, m_axis_tlast, axis_busy, axis_done, m_axis_tdata);
        end
        m_axis_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < RN; i++) model[i] = '0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid || axis_done || s_axil_bvalid || s_axil_rvalid) begin
            errors++; $display("FAIL midrst_after: got tvalid=%0b done=%0b expected 0 0", m_axis_tvalid, axis_done);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            axil_read(addr_of(i), rd, rr, ok, lat);
            checks++;
            if (!ok || rd !== 64'h0) begin errors++; $display("FAIL midrst_reg%0d: got %h expected 0", i, rd); end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        m_axis_tready = 1'b0; axis_read_num = '0; axis_start = 1'b0;
        for (int i = 0; i < RN; i++) model[i] = '0;
        @(negedge clk);
        test_reset();
        test_basic_burst();
        test_stall();
        test_strobe();
        test_single_and_restart();
        test_truncate();
        test_random_burst();
        test_same_edge_write();
        test_concurrent();
        test_aw_without_w();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached expected bench completion");
        $fatal(1);
    end

endmodule
